seq_detector_param: RTL



---
 rtl/seq_detector_param.sv | 100 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial bit-stream detector. One bit of `w` is shifted into a history
//   register on every enabled clock. The block raises a single-cycle `out`
//   pulse either when the last LEN bits equal PATTERN (mode=0) or when the last
//   LEN bits are all the same value (mode=1, run detect). A saturating counter
//   tallies matches since reset.
//
//   Parameters
//     LEN      pattern / run length in bits, legal 2..16
//     PATTERN  target pattern, MSB is the oldest (first received) bit
//     OVERLAP  1: bits of one match may be reused by the next
//              0: history restarts after each match
//     CNT_W    width of match_count
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous active-high reset
//     en           sample enable; w is consumed only when en=1
//     w            serial data bit
//     mode         0 = pattern detect, 1 = run detect
//     out          registered match pulse, one cycle per match
//     match_count  saturating number of matches since reset
//     hist_full    history holds LEN valid bits (fill == LEN)
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic             mode,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             hist_full
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

    logic [LEN-1:0]   hist_q, hist_d, hist_n;
    logic [FW-1:0]    fill_q, fill_d, fill_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q;
    logic             out_q;
    logic             mode_chg;
    logic             pat_ok;
    logic             hit;

    // Candidate history/fill if this edge consumes a bit.
    assign hist_n   = {hist_q[LEN-2:0], w};
    assign fill_n   = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    assign mode_chg = (mode != mode_q);

    // Compare against the stored mode: a mode change edge never matches anyway.
    assign pat_ok = mode_q ? ((hist_n == '0) || (hist_n == '1))
                           : (hist_n == PATTERN);
    assign hit    = en && !mode_chg && (fill_n == FILL_MAX) && pat_ok;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        // History keeps shifting through a mode change; only fill restarts.
        if (en)
            hist_d = hist_n;
        if (mode_chg)
            fill_d = '0;
        else if (en)
            fill_d = (hit && !OVERLAP) ? '0 : fill_n;
        // Saturate instead of wrapping.
        if (hit && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            mode_q <= mode;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            out_q  <= hit;
            mode_q <= mode;
        end
    end

    assign out         = out_q;
    assign match_count = cnt_q;
    assign hist_full   = (fill_q == FILL_MAX);

endmodule
